// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared types and default geometry for the kernel front-end
package kernel_pkg;

  localparam int KD_WIDTH    = 5;
  localparam int KD_HEIGHT   = 5;
  localparam int KD_BITWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN
  } kd_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } kd_tag_t;

endpackage

// File: rtl/kernel_driver_skew_line.sv
// rtl/kernel_driver_skew_line.sv - zero-reset delay line of DEPTH words; DEPTH=0 is a plain wire
module skew_line #(
  parameter int DEPTH    = 1,
  parameter int BITWIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITWIDTH-1:0] i_data,
  output logic [BITWIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;
      assign o_data = i_data;
    end else begin : g_regs
      logic [BITWIDTH-1:0] sr [DEPTH];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
        end else begin
          sr[0] <= i_data;
          for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
      end

      assign o_data = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/kernel_driver.sv
// rtl/kernel_driver.sv - weight/data sequencer with diagonal skew and result tagging for one systolic kernel
// Optional KERNEL_DRIVER_PERF_EN adds saturating vector/bubble counters.
module kernel_driver
  import kernel_pkg::*;
#(
  parameter int WIDTH    = KD_WIDTH,
  parameter int HEIGHT   = KD_HEIGHT,
  parameter int BITWIDTH = KD_BITWIDTH,
  parameter int RES_LAT  = WIDTH + HEIGHT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_w_valid,
  output logic                       o_w_ready,
  input  logic [WIDTH*BITWIDTH-1:0]  i_w_row,
  input  logic [BITWIDTH-1:0]        i_w_bias,
  input  logic                       i_d_valid,
  output logic                       o_d_ready,
  input  logic [HEIGHT*BITWIDTH-1:0] i_d_vec,
  input  logic                       i_d_last,
  output logic                       o_loading_weight,
  output logic [BITWIDTH-1:0]        o_bias,
  output logic [WIDTH*BITWIDTH-1:0]  o_weight,
  output logic [HEIGHT*BITWIDTH-1:0] o_data,
  input  logic [BITWIDTH-1:0]        i_result,
  output logic                       o_r_valid,
  output logic                       o_r_last,
  output logic [BITWIDTH-1:0]        o_r_data,
  output logic                       o_busy
`ifdef KERNEL_DRIVER_PERF_EN
  ,
  output logic [31:0]                o_perf_vectors,
  output logic [31:0]                o_perf_bubbles
`endif
);

  localparam logic [15:0] ROW_LAST   = 16'(HEIGHT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(RES_LAT + HEIGHT - 2);

  kd_state_t state, state_nxt;
  logic [15:0] row_cnt, drain_cnt;
  logic w_acc, d_acc;

  logic [HEIGHT*BITWIDTH-1:0] inj_vec;
  kd_tag_t inj_tag;
  kd_tag_t tag_pipe [RES_LAT];
  kd_tag_t tag_out;

  assign w_acc = i_w_valid & o_w_ready;
  assign d_acc = i_d_valid & o_d_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (w_acc) state_nxt = (HEIGHT == 1) ? ST_STREAM : ST_LOAD;
      ST_LOAD:   if (w_acc && row_cnt == ROW_LAST) state_nxt = ST_STREAM;
      ST_STREAM: if (d_acc && i_d_last) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_w_ready = 1'b0;
    o_d_ready = 1'b0;
    o_busy    = 1'b1;
    case (state)
      ST_IDLE:   begin o_w_ready = 1'b1; o_busy = 1'b0; end
      ST_LOAD:   o_w_ready = 1'b1;
      ST_STREAM: o_d_ready = 1'b1;
      default:   ;
    endcase
  end

  // row_cnt holds rows accepted so far; the bias rides with the first row only
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_cnt   <= '0;
      drain_cnt <= '0;
      o_bias    <= '0;
    end else begin
      if (state == ST_IDLE && w_acc) begin
        row_cnt <= 16'd1;
        o_bias  <= i_w_bias;
      end else if (state == ST_LOAD && w_acc) begin
        row_cnt <= row_cnt + 16'd1;
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 16'd1 : 16'd0;
    end
  end

  assign o_loading_weight = w_acc;
  assign o_weight         = w_acc ? i_w_row : '0;

  // One injection register aligns row 0 with the kernel; rows 1.. then add i cycles of skew
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inj_vec <= '0;
      inj_tag <= '0;
    end else begin
      inj_vec       <= d_acc ? i_d_vec : '0;
      inj_tag.valid <= d_acc;
      inj_tag.last  <= d_acc & i_d_last;
    end
  end

  generate
    for (genvar g = 0; g < HEIGHT; g++) begin : g_skew
      skew_line #(
        .DEPTH   (g),
        .BITWIDTH(BITWIDTH)
      ) u_skew (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_data(inj_vec[g*BITWIDTH +: BITWIDTH]),
        .o_data(o_data[g*BITWIDTH +: BITWIDTH])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < RES_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= inj_tag;
      for (int k = 1; k < RES_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign tag_out   = tag_pipe[RES_LAT-1];
  assign o_r_valid = tag_out.valid;
  assign o_r_last  = tag_out.last;
  assign o_r_data  = tag_out.valid ? i_result : '0;

`ifdef KERNEL_DRIVER_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_vectors <= '0;
      o_perf_bubbles <= '0;
    end else if (state == ST_IDLE && w_acc) begin
      o_perf_vectors <= '0;
      o_perf_bubbles <= '0;
    end else begin
      if (d_acc && o_perf_vectors != '1) o_perf_vectors <= o_perf_vectors + 32'd1;
      if (state == ST_STREAM && !d_acc && o_perf_bubbles != '1)
        o_perf_bubbles <= o_perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/kernel_driver.md
# kernel_driver

Front-end sequencer for the systolic convolution kernel. It accepts weight rows plus bias and input data vectors over valid/ready streams, and drives the kernel's weight-load and data ports with the diagonal skew the array requires. It also tags kernel results with a valid/last strobe after a fixed pipeline latency. It sits between the layer buffer/scheduler and one kernel instance.

## Interface
- WIDTH, 5, kernel columns (weight row length)
- HEIGHT, 5, kernel rows (data vector length, number of weight rows)
- BITWIDTH, 16, word width
- RES_LAT, WIDTH+HEIGHT, cycles from a data vector's row-0 element entering the kernel to its result on the kernel output
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_w_valid / o_w_ready  in/out  1  weight-row handshake
- i_w_row  in  WIDTH×BITWIDTH  weight row, bottom kernel row first
- i_w_bias  in  BITWIDTH  bias, sampled with the first row of a load
- i_d_valid / o_d_ready  in/out  1  data-vector handshake
- i_d_vec  in  HEIGHT×BITWIDTH  one element per kernel row
- i_d_last  in  1  marks the final vector of a frame
- o_loading_weight  out  1  kernel weight-shift enable
- o_bias  out  BITWIDTH  kernel bias input
- o_weight  out  WIDTH×BITWIDTH  kernel weight input
- o_data  out  HEIGHT×BITWIDTH  skewed kernel data input
- i_result  in  BITWIDTH  kernel result output
- o_r_valid / o_r_last / o_r_data  out  1/1/BITWIDTH  result strobe, frame end, data (no backpressure)
- o_busy  out  1  high whenever the FSM is not in IDLE

## Operation
- The FSM has four states: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - o_w_ready=1, o_d_ready=0.
  - An accepted weight row moves the FSM to LOAD, sets row count=1, and captures i_w_bias into o_bias.
- LOAD:
  - o_w_ready=1 until HEIGHT rows have been accepted.
  - When the HEIGHT-th row is accepted, the FSM moves to STREAM on the next cycle.
  - Because rows shift downward, the first accepted row ends in kernel row HEIGHT-1.
- STREAM:
  - o_d_ready=1 and o_w_ready=0.
  - An accepted vector is injected into the skew; a cycle with no acceptance injects zeros (a bubble).
  - Accepting a vector with i_d_last=1 moves the FSM to DRAIN.
- DRAIN:
  - Both readies are 0 and zeros are injected.
  - The FSM stays for RES_LAT+HEIGHT-1 cycles, then returns to IDLE.
  - The next load may begin only from IDLE.
- Weight path:
  - o_loading_weight = accepted weight handshake that cycle.
  - o_weight = i_w_row when loading, else 0.
  - Stalls are allowed: the kernel shifts weights only on load cycles.
- Skew: o_data[i] is the injected element i delayed by i cycles. A triangular register set totals HEIGHT(HEIGHT-1)/2 words, and row 0 has no register.
- Result tagging:
  - A (valid,last) tag pipeline of depth RES_LAT is fed at injection time.
  - Its output gives o_r_valid/o_r_last; o_r_data = i_result when o_r_valid=1, else 0.
- Bubbles produce no o_r_valid. The order of results equals the order of accepted vectors.
- There is no arithmetic: all data passes through unmodified.

## Timing
- Reset values:
  - FSM=IDLE, o_w_ready=1, o_d_ready=0.
  - o_loading_weight, o_bias, o_weight, o_data, o_r_valid, o_r_last, o_r_data, o_busy are all 0.
  - Skew registers and tags are cleared.
- Weight handshake to o_loading_weight/o_weight has 0 latency (combinational from the handshake). o_bias updates the cycle after the first row is accepted.
- A data vector accepted at cycle t appears on o_data[i] at cycle t+1+i, and its result is valid at t+1+RES_LAT.
- The first vector is acceptable one cycle after the HEIGHT-th weight row is accepted.
- i_w_valid in STREAM/DRAIN, or i_d_valid in IDLE/LOAD, is ignored (not accepted).
- Reset mid-LOAD, mid-STREAM or mid-DRAIN aborts immediately: all in-flight tags are discarded and no o_r_valid follows.
- A frame of exactly one vector with i_d_last=1 is legal: o_r_valid and o_r_last are both high on its result.

## Configuration
- KERNEL_DRIVER_PERF_EN defined adds two outputs:
  - o_perf_vectors (32 b, counts accepted data vectors).
  - o_perf_bubbles (32 b, counts STREAM cycles with no acceptance).
- Both counters are cleared by reset and by the IDLE→LOAD transition, and saturate at all-ones.
- KERNEL_DRIVER_PERF_EN undefined: the counters and their ports do not exist; the other behaviour is identical.

## Structure
- The shared package kernel_pkg holds:
  - the FSM state enum (kd_state_t);
  - the result tag struct kd_tag_t {valid,last};
  - the default WIDTH/HEIGHT/BITWIDTH constants.
- The sub-module skew_line(DEPTH, BITWIDTH) is a zero-reset delay line; HEIGHT instances are made with DEPTH=i, and DEPTH=0 is a wire.
- The tag pipeline is built inline.

## Test plan
- Reset, then idle: all outputs equal their reset values, and o_w_ready=1 with no activity.
- WIDTH=HEIGHT=3 load of rows {1,2,3},{4,5,6},{7,8,9} with bias 10 and an i_w_valid gap after row 1:
  - o_loading_weight is high for exactly 3 cycles and low during the gap;
  - o_bias=10;
  - the FSM is in STREAM after row 3.
- Vector {11,22,33} accepted at cycle t:
  - o_data[0]=11 at t+1, o_data[1]=22 at t+2, o_data[2]=33 at t+3;
  - zeros on the other rows in those cycles.
- Vectors A, bubble, B (B with last): o_r_valid at tA+1+RES_LAT and tA+3+RES_LAT only, with o_r_last on B only; the FSM then enters DRAIN, returns to IDLE after RES_LAT+2 cycles, and o_busy drops.
- Reset asserted two cycles after the first vector of a stream: all outputs are 0 immediately and no o_r_valid appears afterwards.
- With KERNEL_DRIVER_PERF_EN: 4 vectors with 2 bubbles give o_perf_vectors=4 and o_perf_bubbles=2, and both counters clear on the next load.
